// File: rtl/logic_loom_pkg.sv
// Shared types and constants for the logic_loom serial link blocks.
package logic_loom_pkg;

  // Default word width used by both ends of the serial link.
  localparam int LL_WORD_W = 4;

  // Occupancy of the one-entry holding register behind the accumulator.
  typedef enum logic {
    HS_EMPTY = 1'b0,
    HS_FULL  = 1'b1
  } ll_hold_state_t;

  // Counter width for a modulo-n count; never narrower than one bit.
  function automatic int ll_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ll_bit_counter.sv
// Modulo-MOD bit counter with enable, soft clear and a last-position flag.
// Shared by the shift-in and shift-out ends of the serial link.
module ll_bit_counter
  import logic_loom_pkg::*;
#(
  parameter int MOD = LL_WORD_W,
  localparam int CW = ll_cnt_w(MOD)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last
);

  localparam logic [CW-1:0] LAST_VAL = CW'(MOD - 1);

  assign last = (cnt == LAST_VAL);

  // Count enabled cycles, wrapping explicitly so non-power-of-2 moduli work.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/serial_word_rx.sv
// Serial-in, parallel-out word receiver: assembles MSB-first words one bit
// per shift strobe and hands them out through a one-entry valid/ready buffer.
module serial_word_rx
  import logic_loom_pkg::*;
#(
  parameter int WIDTH = LL_WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             shift,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = ll_cnt_w(WIDTH);

  // Only the WIDTH-1 bits received before the final one need storing; the
  // final bit comes straight from din on the completing cycle.
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt;
  logic             cnt_last;
  logic             complete;

  ll_hold_state_t   state_q;
  ll_hold_state_t   state_d;
  logic             load_word;
  logic             drop_word;

  ll_bit_counter #(
    .MOD (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (shift),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  assign word     = {acc, din};
  assign complete = shift && cnt_last;

  // Shift in one bit per strobe; empty the accumulator when a word completes.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc <= '0;
    end else if (shift) begin
      if (cnt_last) begin
        acc <= '0;
      end else begin
        acc <= word[WIDTH-2:0];
      end
    end
  end

  // Holding-state register.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_q <= HS_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Decide whether a completed word is loaded or dropped, and track occupancy.
  always_comb begin
    state_d   = state_q;
    load_word = 1'b0;
    drop_word = 1'b0;
    unique case (state_q)
      HS_EMPTY: begin
        if (complete) begin
          load_word = 1'b1;
          state_d   = HS_FULL;
        end
      end
      HS_FULL: begin
        if (complete) begin
          if (dout_ready) begin
            load_word = 1'b1;
          end else begin
            drop_word = 1'b1;
          end
        end else if (dout_ready) begin
          state_d = HS_EMPTY;
        end
      end
      default: begin
        state_d = HS_EMPTY;
      end
    endcase
  end

  // Holding register; left stale after a transfer rather than cleared.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      dout <= '0;
    end else if (load_word) begin
      dout <= word;
    end
  end

  // Sticky overrun flag, cleared only by reset or soft clear.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      overrun <= 1'b0;
    end else if (drop_word) begin
      overrun <= 1'b1;
    end
  end

  assign dout_valid = (state_q == HS_FULL);
  assign busy       = (cnt != '0);

endmodule

// File: tb/tb_serial_word_rx.sv
// Self-checking bench for serial_word_rx with a transfer scoreboard.
module tb_serial_word_rx;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             din;
  logic             shift;
  logic             clr;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             overrun;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] sb[$];

  serial_word_rx #(
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .shift      (shift),
    .clr        (clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then wait until just after the next rising edge.
  task automatic applyStimulus(input logic d, input logic s, input logic r, input logic c);
    din        = d;
    shift      = s;
    dout_ready = r;
    clr        = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [WIDTH-1:0] e_dout,
                          input logic e_valid, input logic e_busy, input logic e_ovr);
    checkOutput({tag, ".dout"}, 32'(dout), 32'(e_dout));
    checkOutput({tag, ".valid"}, 32'(dout_valid), 32'(e_valid));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(e_busy));
    checkOutput({tag, ".overrun"}, 32'(overrun), 32'(e_ovr));
  endtask

  // Compare every handshake transfer against the oldest expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && clr === 1'b0 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("xfer_unexpected", 32'(dout), 32'hFFFF_FFFF);
      end else begin
        checkOutput("xfer", 32'(dout), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] w;
    logic [7:0]       stream;
    int               k;

    rst_n      = 1'b0;
    din        = 1'b0;
    shift      = 1'b0;
    clr        = 1'b0;
    dout_ready = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkAll("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkAll("idle", 4'b0000, 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] single word");
    w = 4'b1011;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i == 0) sb.push_back(w);
      applyStimulus(w[i], 1'b1, 1'b0, 1'b0);
      checkOutput("single.busy", 32'(busy), 32'(i != 0));
      checkOutput("single.valid", 32'(dout_valid), 32'(i == 0));
    end
    checkAll("single", 4'b1011, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("single_consumed", 4'b1011, 1'b0, 1'b0, 1'b0);

    $display("[TB] back-to-back, ready held high");
    stream = 8'b1011_0110;
    for (int i = 7; i >= 0; i--) begin
      k = 8 - i;
      if (i == 4) sb.push_back(stream[7:4]);
      if (i == 0) sb.push_back(stream[3:0]);
      applyStimulus(stream[i], 1'b1, 1'b1, 1'b0);
      checkOutput("b2b.valid", 32'(dout_valid), 32'(k == 4 || k == 8));
      if (k >= 4) checkOutput("b2b.dout", 32'(dout), (k == 8) ? 32'h6 : 32'hB);
      checkOutput("b2b.overrun", 32'(overrun), 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("b2b_drained.valid", 32'(dout_valid), 32'h0);

    $display("[TB] back-to-back, consume on completing edge");
    for (int i = 7; i >= 0; i--) begin
      k = 8 - i;
      if (i == 4) sb.push_back(stream[7:4]);
      if (i == 0) sb.push_back(stream[3:0]);
      applyStimulus(stream[i], 1'b1, (k == 8) ? 1'b1 : 1'b0, 1'b0);
      checkOutput("nogap.valid", 32'(dout_valid), 32'(k >= 4));
      if (k >= 4) checkOutput("nogap.dout", 32'(dout), (k == 8) ? 32'h6 : 32'hB);
      checkOutput("nogap.overrun", 32'(overrun), 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkAll("nogap_hold", 4'b0110, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("nogap_drained.valid", 32'(dout_valid), 32'h0);

    $display("[TB] overrun");
    for (int i = 7; i >= 0; i--) begin
      k = 8 - i;
      if (i == 4) sb.push_back(stream[7:4]);
      applyStimulus(stream[i], 1'b1, 1'b0, 1'b0);
      checkOutput("ovr.valid", 32'(dout_valid), 32'(k >= 4));
      checkOutput("ovr.overrun", 32'(overrun), 32'(k == 8));
      if (k >= 4) checkOutput("ovr.dout", 32'(dout), 32'hB);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("ovr_consumed", 4'b1011, 1'b0, 1'b0, 1'b1);

    $display("[TB] mid-word clear");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("clr_pre.busy", 32'(busy), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkAll("clr", 4'b0000, 1'b0, 1'b0, 1'b0);
    w = 4'b0001;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i == 0) sb.push_back(w);
      applyStimulus(w[i], 1'b1, 1'b0, 1'b0);
    end
    checkAll("clr_word", 4'b0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("clr_drained.valid", 32'(dout_valid), 32'h0);

    $display("[TB] gapped strobe");
    w = 4'b1010;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i == 0) sb.push_back(w);
      applyStimulus(w[i], 1'b1, 1'b0, 1'b0);
      if (i != 0) begin
        for (int g = 0; g < 3; g++) begin
          applyStimulus(~w[i], 1'b0, 1'b0, 1'b0);
          checkOutput("gap.busy", 32'(busy), 32'h1);
          checkOutput("gap.valid", 32'(dout_valid), 32'h0);
        end
      end
    end
    checkAll("gap_word", 4'b1010, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("gap_drained.valid", 32'(dout_valid), 32'h0);

    checkOutput("sb_left", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
